// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - fetch-stage bundle: PC/stall/redirect inputs, byte-wide memory port, IF/ID outputs.
interface if_fetch_if;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [5:0]  stall;
  logic        set_pc_i;
  logic        mem_busy_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;
  logic        if_memreq_o;
  logic [31:0] if_mem_addr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        if_stall_req_o;

  modport master (
    input  ce_i, pc_i, stall, set_pc_i, mem_busy_i, mem_rvalid_i, mem_rdata_i,
    output if_memreq_o, if_mem_addr_o, if_pc_o, if_inst_o, if_valid_o, if_stall_req_o
  );

  modport slave (
    output ce_i, pc_i, stall, set_pc_i, mem_busy_i, mem_rvalid_i, mem_rdata_i,
    input  if_memreq_o, if_mem_addr_o, if_pc_o, if_inst_o, if_valid_o, if_stall_req_o
  );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: assembles 4 LE bytes per word, stall/flush aware.
// Optional direct-mapped one-word I-cache enabled by defining IF_ICACHE_EN.
module if_fetch #(
  parameter int ICACHE_LINES = 128
) (
  input  logic         clk,
  input  logic         rst,
  if_fetch_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [23:0] r_buf;
  logic [31:0] r_addr;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_memreq;
  logic        r_valid;
  logic        w_start;
  logic        w_done;
  logic        w_hit;
  logic        w_hit_start;
  logic        w_stall_req;
  logic        w_unused_stall;

  assign w_unused_stall = ^{bus.stall[5:2], bus.stall[0]};

`ifdef IF_ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [TAG_W-1:0]        r_tag  [ICACHE_LINES];
  logic [31:0]             r_data [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] r_lvld;
  logic [IDX_W-1:0]        w_idx;
  logic [IDX_W-1:0]        w_widx;
  logic [31:0]             w_hit_data;

  assign w_idx      = bus.pc_i[IDX_W+1:2];
  assign w_widx     = r_addr[IDX_W+1:2];
  assign w_hit      = r_lvld[w_idx] && (r_tag[w_idx] == bus.pc_i[31:IDX_W+2]);
  assign w_hit_data = r_data[w_idx];

  // Tag/data arrays carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_done) begin
      r_tag[w_widx]  <= r_addr[31:IDX_W+2];
      r_data[w_widx] <= {bus.mem_rdata_i, r_buf};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvld <= '0;
    end else if (w_done) begin
      r_lvld[w_widx] <= 1'b1;
    end
  end
`else
  logic [31:0] w_hit_data;
  assign w_hit      = 1'b0;
  assign w_hit_data = 32'h0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_hit_start = 1'b0;
    w_stall_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall_req = bus.mem_busy_i && !w_hit;
        if (bus.ce_i && !bus.set_pc_i) begin
          if (w_hit) begin
            w_hit_start = 1'b1;
            w_next      = S_HOLD;
          end else if (!bus.mem_busy_i) begin
            w_start = 1'b1;
            w_next  = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_stall_req = 1'b1;
        // A redirect coinciding with the last byte discards the word.
        if (bus.set_pc_i) begin
          w_next = S_IDLE;
        end else if (bus.mem_rvalid_i && (r_cnt == 2'd3)) begin
          w_done = 1'b1;
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        w_stall_req = 1'b1;
        if (bus.set_pc_i || !bus.stall[1]) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 2'd0;
      r_buf    <= 24'h0;
      r_addr   <= 32'h0;
      r_pc     <= 32'h0;
      r_inst   <= 32'h0;
      r_memreq <= 1'b0;
      r_valid  <= 1'b0;
    end else if (bus.set_pc_i) begin
      r_cnt    <= 2'd0;
      r_memreq <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr   <= bus.pc_i;
        r_memreq <= 1'b1;
        r_cnt    <= 2'd0;
      end
      if (w_hit_start) begin
        r_inst  <= w_hit_data;
        r_pc    <= bus.pc_i;
        r_valid <= 1'b1;
      end
      if ((r_state == S_FETCH) && bus.mem_rvalid_i) begin
        case (r_cnt)
          2'd0:    r_buf[7:0]   <= bus.mem_rdata_i;
          2'd1:    r_buf[15:8]  <= bus.mem_rdata_i;
          2'd2:    r_buf[23:16] <= bus.mem_rdata_i;
          default: r_buf        <= r_buf;
        endcase
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_done) begin
        r_inst   <= {bus.mem_rdata_i, r_buf};
        r_pc     <= r_addr;
        r_valid  <= 1'b1;
        r_memreq <= 1'b0;
      end
      if ((r_state == S_HOLD) && !bus.stall[1]) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.if_memreq_o    = r_memreq;
  assign bus.if_mem_addr_o  = r_addr;
  assign bus.if_pc_o        = r_pc;
  assign bus.if_inst_o      = r_inst;
  assign bus.if_valid_o     = r_valid;
  assign bus.if_stall_req_o = w_stall_req;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed bench for if_fetch (cache scenario built when IF_ICACHE_EN is defined).
module tb_if_fetch;
  localparam int LINES = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  if_fetch_if bus ();

  if_fetch #(.ICACHE_LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ce_i         = 1'b0;
    bus.pc_i         = 32'h0;
    bus.stall        = 6'h0;
    bus.set_pc_i     = 1'b0;
    bus.mem_busy_i   = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 8'h0;
  endtask

  task automatic send_bytes(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = w[8*k +: 8];
      tick();
    end
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic start_fetch(input logic [31:0] pc);
    bus.ce_i = 1'b1;
    bus.pc_i = pc;
    tick();
    bus.ce_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.if_memreq_o, bus.if_valid_o, bus.if_stall_req_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {bus.if_memreq_o, bus.if_valid_o, bus.if_stall_req_o});
    end
    checks++;
    if ({bus.if_mem_addr_o, bus.if_pc_o, bus.if_inst_o} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {bus.if_mem_addr_o, bus.if_pc_o, bus.if_inst_o});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    start_fetch(32'h0000_0000);
    checks++;
    if ({bus.if_memreq_o, bus.if_stall_req_o, bus.if_valid_o} !== 3'b110) begin
      failures++;
      $display("FAIL basic_req got=%b exp=110", {bus.if_memreq_o, bus.if_stall_req_o, bus.if_valid_o});
    end
    send_bytes(32'h0050_0513);
    checks++;
    if ({bus.if_valid_o, bus.if_memreq_o} !== 2'b10 || bus.if_inst_o !== 32'h0050_0513 || bus.if_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL basic_done got=v%b r%b i=%h pc=%h exp=v1 r0 i=00500513 pc=0",
               bus.if_valid_o, bus.if_memreq_o, bus.if_inst_o, bus.if_pc_o);
    end
    tick();
    checks++;
    if ({bus.if_valid_o, bus.if_stall_req_o} !== 2'b00) begin
      failures++;
      $display("FAIL basic_consume got=%b exp=00", {bus.if_valid_o, bus.if_stall_req_o});
    end
  endtask

  task automatic test_stall_hold();
    start_fetch(32'h0000_0104);
    checks++;
    if (bus.if_mem_addr_o !== 32'h104) begin
      failures++;
      $display("FAIL hold_addr got=%h exp=00000104", bus.if_mem_addr_o);
    end
    bus.stall = 6'b000010;
    send_bytes(32'hDEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.if_valid_o, bus.if_stall_req_o} !== 2'b11 || bus.if_inst_o !== 32'hDEAD_BEEF || bus.if_pc_o !== 32'h104) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got=v%b s%b i=%h pc=%h exp=v1 s1 i=deadbeef pc=104",
                 c, bus.if_valid_o, bus.if_stall_req_o, bus.if_inst_o, bus.if_pc_o);
      end
    end
    bus.stall = 6'b0;
    bus.ce_i  = 1'b1;
    bus.pc_i  = 32'h0000_0108;
    tick();
    checks++;
    if ({bus.if_valid_o, bus.if_stall_req_o, bus.if_memreq_o} !== 3'b000) begin
      failures++;
      $display("FAIL hold_release got=%b exp=000", {bus.if_valid_o, bus.if_stall_req_o, bus.if_memreq_o});
    end
    tick();
    checks++;
    if (bus.if_memreq_o !== 1'b1 || bus.if_mem_addr_o !== 32'h108) begin
      failures++;
      $display("FAIL hold_next_req got=r%b a=%h exp=r1 a=00000108", bus.if_memreq_o, bus.if_mem_addr_o);
    end
    bus.ce_i     = 1'b0;
    bus.set_pc_i = 1'b1;
    tick();
    bus.set_pc_i = 1'b0;
  endtask

  task automatic test_busy();
    bus.ce_i       = 1'b1;
    bus.pc_i       = 32'h0000_0040;
    bus.mem_busy_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({bus.if_memreq_o, bus.if_stall_req_o} !== 2'b01) begin
        failures++;
        $display("FAIL busy_wait cyc=%0d got=%b exp=01", c, {bus.if_memreq_o, bus.if_stall_req_o});
      end
    end
    bus.mem_busy_i = 1'b0;
    tick();
    bus.ce_i = 1'b0;
    checks++;
    if (bus.if_memreq_o !== 1'b1 || bus.if_mem_addr_o !== 32'h40) begin
      failures++;
      $display("FAIL busy_release got=r%b a=%h exp=r1 a=00000040", bus.if_memreq_o, bus.if_mem_addr_o);
    end
    send_bytes(32'h1122_3344);
    checks++;
    if (bus.if_valid_o !== 1'b1 || bus.if_inst_o !== 32'h1122_3344) begin
      failures++;
      $display("FAIL busy_inst got=v%b i=%h exp=v1 i=11223344", bus.if_valid_o, bus.if_inst_o);
    end
    tick();
  endtask

  task automatic test_flush();
    start_fetch(32'h0000_0080);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 8'hAA;
    tick();
    bus.mem_rdata_i  = 8'hBB;
    tick();
    bus.set_pc_i     = 1'b1;
    bus.mem_rdata_i  = 8'hCC;
    tick();
    checks++;
    if ({bus.if_memreq_o, bus.if_valid_o, bus.if_stall_req_o} !== 3'b000) begin
      failures++;
      $display("FAIL flush_drop got=%b exp=000", {bus.if_memreq_o, bus.if_valid_o, bus.if_stall_req_o});
    end
    bus.set_pc_i    = 1'b0;
    bus.mem_rdata_i = 8'hDD;
    tick();
    bus.mem_rvalid_i = 1'b0;
    checks++;
    if ({bus.if_memreq_o, bus.if_valid_o} !== 2'b00) begin
      failures++;
      $display("FAIL flush_late_byte got=%b exp=00", {bus.if_memreq_o, bus.if_valid_o});
    end
    start_fetch(32'h0000_0300);
    checks++;
    if (bus.if_memreq_o !== 1'b1 || bus.if_mem_addr_o !== 32'h300) begin
      failures++;
      $display("FAIL flush_new_req got=r%b a=%h exp=r1 a=00000300", bus.if_memreq_o, bus.if_mem_addr_o);
    end
    send_bytes(32'h0A0B_0C0D);
    checks++;
    if (bus.if_valid_o !== 1'b1 || bus.if_inst_o !== 32'h0A0B_0C0D || bus.if_pc_o !== 32'h300) begin
      failures++;
      $display("FAIL flush_fresh got=v%b i=%h pc=%h exp=v1 i=0a0b0c0d pc=300",
               bus.if_valid_o, bus.if_inst_o, bus.if_pc_o);
    end
    tick();
  endtask

  task automatic test_flush_last_byte();
    start_fetch(32'h0000_0090);
    bus.mem_rvalid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.mem_rdata_i = 8'h10 + 8'(k);
      tick();
    end
    bus.mem_rdata_i = 8'h77;
    bus.set_pc_i    = 1'b1;
    tick();
    bus.set_pc_i     = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    checks++;
    if ({bus.if_valid_o, bus.if_memreq_o} !== 2'b00) begin
      failures++;
      $display("FAIL flush_last got=%b exp=00", {bus.if_valid_o, bus.if_memreq_o});
    end
  endtask

  task automatic test_reset_mid();
    start_fetch(32'h0000_0500);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 8'h99;
    tick();
    bus.mem_rvalid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.if_memreq_o, bus.if_stall_req_o, bus.if_valid_o} !== 3'b000 || bus.if_mem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL rst_async got=r%b s%b v%b a=%h exp=000 a=0",
               bus.if_memreq_o, bus.if_stall_req_o, bus.if_valid_o, bus.if_mem_addr_o);
    end
    tick();
    rst = 1'b1;
    tick();
    start_fetch(32'h0000_0504);
    send_bytes(32'h0102_0304);
    checks++;
    if (bus.if_valid_o !== 1'b1 || bus.if_inst_o !== 32'h0102_0304 || bus.if_pc_o !== 32'h504) begin
      failures++;
      $display("FAIL rst_restart got=v%b i=%h pc=%h exp=v1 i=01020304 pc=504",
               bus.if_valid_o, bus.if_inst_o, bus.if_pc_o);
    end
    tick();
  endtask

`ifdef IF_ICACHE_EN
  task automatic test_icache();
    start_fetch(32'h0000_0200);
    checks++;
    if (bus.if_memreq_o !== 1'b1) begin
      failures++;
      $display("FAIL ic_miss1 got=%b exp=1", bus.if_memreq_o);
    end
    send_bytes(32'hCAFE_F00D);
    tick();
    bus.set_pc_i = 1'b1;
    tick();
    bus.set_pc_i   = 1'b0;
    bus.mem_busy_i = 1'b1;
    start_fetch(32'h0000_0200);
    bus.mem_busy_i = 1'b0;
    checks++;
    if ({bus.if_valid_o, bus.if_memreq_o} !== 2'b10 || bus.if_inst_o !== 32'hCAFE_F00D || bus.if_pc_o !== 32'h200) begin
      failures++;
      $display("FAIL ic_hit got=v%b r%b i=%h pc=%h exp=v1 r0 i=cafef00d pc=200",
               bus.if_valid_o, bus.if_memreq_o, bus.if_inst_o, bus.if_pc_o);
    end
    tick();
    start_fetch(32'h0000_0200 + 32'(4 * LINES));
    checks++;
    if (bus.if_memreq_o !== 1'b1) begin
      failures++;
      $display("FAIL ic_alias_miss got=%b exp=1", bus.if_memreq_o);
    end
    send_bytes(32'h1234_5678);
    tick();
    start_fetch(32'h0000_0200 + 32'(4 * LINES));
    checks++;
    if ({bus.if_valid_o, bus.if_memreq_o} !== 2'b10 || bus.if_inst_o !== 32'h1234_5678) begin
      failures++;
      $display("FAIL ic_replaced_hit got=v%b r%b i=%h exp=v1 r0 i=12345678",
               bus.if_valid_o, bus.if_memreq_o, bus.if_inst_o);
    end
    tick();
    start_fetch(32'h0000_0200);
    checks++;
    if ({bus.if_memreq_o, bus.if_valid_o} !== 2'b10) begin
      failures++;
      $display("FAIL ic_evicted got=%b exp=10", {bus.if_memreq_o, bus.if_valid_o});
    end
    bus.set_pc_i = 1'b1;
    tick();
    bus.set_pc_i = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_busy();
    test_flush();
    test_flush_last_byte();
    test_reset_mid();
`ifdef IF_ICACHE_EN
    test_icache();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
